// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types for the mux_eight scan sequencer.
// Channel count, select width and FSM state encoding.
package mux_scan_ctrl_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the next enabled channel above the current select,
// or the lowest enabled channel when starting a frame.
module mux_scan_next_ch
  import mux_scan_ctrl_pkg::*;
(
  input  logic [N_CH-1:0]  mask_i,
  input  logic [SEL_W-1:0] cur_i,
  input  logic             from_start_i,
  output logic [SEL_W-1:0] nxt_o,
  output logic             found_o
);

  // Descending walk so the lowest qualifying index wins.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_i[i] &&
          (from_start_i || (SEL_W'(i) > cur_i))) begin
        nxt_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 8:1 mux: steps sel through enabled
// channels, samples after settling, hands off 8-bit frames.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             mode,
  input  logic             stop,
  input  logic             mux_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N_CH-1:0]  data,
  output logic             data_valid,
  input  logic             data_ready
);

  localparam int CNT_W =
    (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(SETTLE_CYCLES);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic              mode_q, mode_d;
  logic              stop_q, stop_d;
  logic [N_CH-1:0]   acc_q, acc_d;
  logic [N_CH-1:0]   data_q, data_d;

  logic [N_CH-1:0]   nc_mask;
  logic              nc_from_start;
  logic [SEL_W-1:0]  nc_nxt;
  logic              nc_found;
  logic [N_CH-1:0]   acc_smp;

  // In IDLE the live mask is searched so sel is valid on entry.
  assign nc_mask       = (state_q == IDLE) ? ch_mask : mask_q;
  assign nc_from_start = (state_q != SETTLE);

  mux_scan_next_ch u_next_ch (
    .mask_i       (nc_mask),
    .cur_i        (sel_q),
    .from_start_i (nc_from_start),
    .nxt_o        (nc_nxt),
    .found_o      (nc_found)
  );

  always_comb begin
    acc_smp        = acc_q;
    acc_smp[sel_q] = mux_in;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    acc_d   = acc_q;
    data_d  = data_q;

    if (state_q != IDLE && stop) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        sel_d  = '0;
        if (start) begin
          mask_d = ch_mask;
          mode_d = mode;
          acc_d  = '0;
          if (nc_found) begin
            sel_d   = nc_nxt;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            data_d  = '0;
            state_d = HOLD;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          acc_d = acc_smp;
          if (nc_found) begin
            sel_d = nc_nxt;
            cnt_d = CNT_LOAD;
          end else begin
            data_d  = acc_smp;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (data_ready) begin
          // A stop arriving with the handshake still ends the run.
          if (mode_q && !stop_q && !stop) begin
            acc_d = '0;
            if (nc_found) begin
              sel_d   = nc_nxt;
              cnt_d   = CNT_LOAD;
              state_d = SETTLE;
            end else begin
              data_d = '0;
            end
          end else begin
            sel_d   = '0;
            stop_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      stop_q  <= 1'b0;
      acc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = (state_q != IDLE);
  assign data       = data_q;
  assign data_valid = (state_q == HOLD);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with a behavioural
// 8:1 mux closing the loop from sel back to mux_in.
module tb_mux_scan_ctrl;

  localparam int S = 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] ch_mask;
  logic       mode;
  logic       stop;
  logic       mux_in;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;

  logic [7:0] mux_i;
  logic [7:0] sb[$];
  int         checks;
  int         errors;

  assign mux_in = mux_i[sel];

  mux_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ch_mask    (ch_mask),
    .mode       (mode),
    .stop       (stop),
    .mux_in     (mux_in),
    .sel        (sel),
    .busy       (busy),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] m,
                             input logic md);
    sb.push_back(m & mux_i);
    ch_mask = m;
    mode    = md;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    ch_mask = 8'($urandom);
    mode    = 1'($urandom);
  endtask

  // Entered right after the edge that began the frame.
  task automatic scan(input logic [7:0] m,
                      input int stop_at);
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        for (int k = 0; k <= S; k++) begin
          chk("sel_step", 32'(sel), 32'(c));
          chk("valid_early", 32'(data_valid), 32'(0));
          chk("busy_scan", 32'(busy), 32'(1));
          if (c == stop_at && k == 0) stop = 1'b1;
          tick();
          stop = 1'b0;
        end
      end
    end
    chk("valid_rise", 32'(data_valid), 32'(1));
  endtask

  task automatic deliver(input logic busy_after);
    logic [7:0] exp;
    chk("valid_hs", 32'(data_valid), 32'(1));
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'(1));
    end else begin
      exp = sb.pop_front();
      chk("data", 32'(data), 32'(exp));
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("valid_drop", 32'(data_valid), 32'(0));
    chk("busy_after", 32'(busy), 32'(busy_after));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    ch_mask    = '0;
    mode       = 1'b0;
    stop       = 1'b0;
    data_ready = 1'b0;
    mux_i      = '0;
    tick();
    tick();
    chk("rst_sel", 32'(sel), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_valid", 32'(data_valid), 32'(0));
    rst_n = 1'b1;
    tick();

    // All channels, alternating inputs
    mux_i = 8'h55;
    start_frame(8'hFF, 1'b0);
    scan(8'hFF, -1);
    deliver(1'b0);
    chk("idle_sel", 32'(sel), 32'(0));

    // Sparse mask, upper channels only
    mux_i = 8'hFF;
    start_frame(8'hA0, 1'b0);
    scan(8'hA0, -1);
    deliver(1'b0);

    // Empty mask: frame in one cycle, sel untouched
    start_frame(8'h00, 1'b0);
    scan(8'h00, -1);
    chk("empty_sel", 32'(sel), 32'(0));
    deliver(1'b0);

    // Continuous mode with backpressure and ignored starts
    mux_i = 8'h3C;
    start_frame(8'h6C, 1'b1);
    scan(8'h6C, -1);
    held = sb[0];
    for (int i = 0; i < 5; i++) begin
      start   = i[0];
      ch_mask = 8'hFF;
      mode    = 1'b0;
      tick();
      chk("bp_valid", 32'(data_valid), 32'(1));
      chk("bp_data", 32'(data), 32'(held));
      chk("bp_sel", 32'(sel), 32'(6));
    end
    start = 1'b0;
    deliver(1'b1);
    mux_i = 8'hC3;
    sb.push_back(8'h6C & mux_i);
    scan(8'h6C, -1);
    stop = 1'b1;
    deliver(1'b0);
    stop = 1'b0;
    chk("stop_hs_sel", 32'(sel), 32'(0));

    // Stop mid-frame in continuous mode
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mux_i = 8'h09;
    start_frame(8'h0F, 1'b1);
    scan(8'h0F, 2);
    deliver(1'b0);
    tick();
    tick();
    chk("stop_busy", 32'(busy), 32'(0));
    chk("stop_valid", 32'(data_valid), 32'(0));
    chk("stop_sel", 32'(sel), 32'(0));

    // Asynchronous reset in the middle of a scan
    mux_i = 8'hFF;
    start_frame(8'hFF, 1'b0);
    for (int i = 0; i < 3 * (S + 1); i++) tick();
    chk("pre_rst_sel", 32'(sel), 32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'(0));
    chk("arst_data", 32'(data), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_valid", 32'(data_valid), 32'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    mux_i = 8'h01;
    start_frame(8'h01, 1'b0);
    scan(8'h01, -1);
    deliver(1'b0);
    chk("sb_drain", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Scan sequencer that sits directly upstream of the 8:1 single-bit mux (mux_eight). It drives the mux 3-bit select through the enabled channels and samples the mux result after a programmable settle time. It then assembles the sampled bits into an 8-bit word and delivers it over a valid/ready handshake. Supports single-shot and continuous scanning.

Parameters:
SETTLE_CYCLES, 1, extra cycles each select value is held before the mux result is sampled (0 = sample in the first cycle sel is valid)

Ports:
clk  input  1  system clock; single clock domain, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  start a scan; ignored unless busy=0 and data_valid=0
ch_mask  input  8  channel-enable mask; latched on accepted start; bit i enables mux input Ii
mode  input  1  latched on accepted start; 0 = single-shot, 1 = continuous
stop  input  1  request end of continuous scanning; sticky until frame boundary
mux_in  input  1  mux result (mux_eight.result)
sel  output  3  mux select (drives mux_eight.s)
busy  output  1  high from accepted start until return to IDLE
data  output  8  assembled frame; bit i = sample of channel i, 0 for disabled channels
data_valid  output  1  frame available; held until data_ready
data_ready  input  1  downstream accepts the frame when high together with data_valid

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate, independent of clk):
  - State = IDLE; sel=0, busy=0, data=0, data_valid=0.
  - Internal mask, mode, stop flag, settle counter and accumulator cleared.
  - An in-progress scan is discarded; no partial frame is output.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - sel=0, busy=0.
  - start=1: latch ch_mask/mode, clear accumulator, set busy=1.
  - If mask!=0: sel = lowest enabled channel, counter = SETTLE_CYCLES, go SETTLE.
  - If mask==0: data=8'h00, go HOLD.
- SETTLE:
  - Counter>0: decrement; sel is held.
  - Counter==0: accumulator[sel] <= mux_in.
    - If a higher enabled channel exists: sel <= next enabled channel, counter reloaded.
    - Otherwise: data <= accumulator including this sample, go HOLD.
  - Each enabled channel occupies exactly SETTLE_CYCLES+1 cycles.
  - Channels are visited in ascending index only; there is no wrap within a frame.
- HOLD:
  - data_valid=1; data and sel (last channel) are stable; no sampling.
  - On data_valid & data_ready, data_valid drops next cycle.
    - If mode=1 and stop flag clear: restart the scan from the lowest enabled channel with the latched mask; accumulator cleared.
    - Otherwise: go IDLE, busy=0.
- Latency: with k enabled channels, data_valid rises (SETTLE_CYCLES+1)*k cycles after the start edge; 1 cycle when mask==0.
- stop:
  - Any cycle stop=1 while busy sets the sticky flag.
  - The current frame always completes and is delivered.
  - The flag clears on the return to IDLE.
  - stop in IDLE has no effect.
- start while busy or data_valid=1 is ignored; a new mask/mode takes effect only at the next accepted start.
- Simultaneous handshake and stop in HOLD: the stop wins, so the block goes to IDLE.
- Backpressure: the block stalls indefinitely in HOLD; no frames are dropped or overwritten.

Decomposition:
- Shared package: N_CH=8, SEL_W=3, state enum (IDLE, SETTLE, HOLD).
- One combinational sub-module, mux_scan_next_ch:
  - Inputs: mask, current index, and a "from start" flag.
  - Outputs: next enabled index above current (or the lowest enabled index when "from start"), and a found flag.
  - Used by the IDLE and SETTLE transitions.

Test Plan:
- SETTLE_CYCLES=1, mask 8'hFF, mode 0; mux inputs I0..I7 = 1,0,1,0,1,0,1,0 -> sel steps 0..7, each held 2 cycles; data_valid rises 16 cycles after start; data=8'h55; busy=0 after the handshake.
- mask 8'hA0, all mux inputs 1 -> sel visits only 5 then 7; data_valid after 4 cycles; data=8'hA0.
- mask 8'h00 -> data_valid 1 cycle after start; data=8'h00; sel stays 0.
- data_ready held low 5 cycles in HOLD -> data_valid stays 1; data and sel unchanged; start pulses ignored. Continuous mode: after acceptance the scan restarts at the lowest enabled channel.
- mode 1, mask 8'h0F, stop pulsed while sel=2 -> frame completes through sel=3 and is delivered; then IDLE, busy=0; no further scan.
- rst_n low mid-scan at sel=3 -> sel, data, busy and data_valid go to 0 asynchronously. After release, a new start with mask 8'h01 and I0=1 yields data=8'h01.
